ripple_add_sequencer: RTL and testbench

- Multi-precision add/subtract controller that time-shares one 4-bit ripple-carry adder slice.
- Adds or subtracts WIDTH-bit operands one nibble per cycle, from LSB to MSB, holding the carry in a register between cycles.
- Sits between a register-file/ALU front end and the 4-bit adder datapath, and sequences it with a start/done handshake.

---
 rtl/add_seq_pkg.sv | 30 +++
 rtl/adder4_slice.sv | 35 +++
 rtl/ripple_add_sequencer.sv | 149 ++++++++++++++
 tb/tb_ripple_add_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_seq_pkg
//  Purpose  : Shared types and constants for the nibble-serial add/subtract
//             sequencer and its 4-bit adder slice.
//  Revision : 1.0  initial release
// ============================================================================
package add_seq_pkg;

    // Width of the shared ripple-carry adder slice
    localparam int SLICE_W = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operation encodings
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow: the carry into the sign bit disagrees with the carry out
    function automatic logic signed_ovf(input logic c_into_msb, input logic c_out);
        return c_into_msb ^ c_out;
    endfunction

endpackage : add_seq_pkg
`default_nettype wire

// File: rtl/adder4_slice.sv
`default_nettype none
// ============================================================================
//  Module   : adder4_slice
//  Purpose  : Purely combinational 4-bit ripple-carry adder. Exposes both the
//             carry into bit 3 (for signed overflow) and the carry out.
//  Revision : 1.0  initial release
// ============================================================================
module adder4_slice
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               c3,
    output logic               cout
);

    // carry[i] is the carry into bit i; carry[SLICE_W] leaves the slice
    logic [SLICE_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
            assign s[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    endgenerate

    assign c3   = carry[SLICE_W-1];
    assign cout = carry[SLICE_W];

endmodule : adder4_slice
`default_nettype wire

// File: rtl/ripple_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ripple_add_sequencer
//  Purpose  : Multi-precision add/subtract that time-shares one 4-bit adder
//             slice, processing one nibble per cycle from LSB to MSB with the
//             carry held in a register between passes. Start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module ripple_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e             state_q;
    logic [WIDTH-1:0]   a_q;        // operand A as accepted
    logic [WIDTH-1:0]   b_q;        // operand B, already inverted for subtract
    logic [WIDTH-1:0]   acc_q;      // partial result, filled nibble by nibble
    logic [WIDTH-1:0]   acc_d;
    logic               carry_q;    // carry between nibble passes
    logic [IDX_W-1:0]   idx_q;      // nibble currently on the slice

    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    // Slice interface
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_c3;
    logic               slice_cout;

    // Route the active nibble to the slice and merge its sum into the accumulator
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        acc_d   = acc_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a                     = a_q[i*SLICE_W +: SLICE_W];
                slice_b                     = b_q[i*SLICE_W +: SLICE_W];
                acc_d[i*SLICE_W +: SLICE_W] = slice_s;
            end
        end
    end

    adder4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .c3   (slice_c3),
        .cout (slice_cout)
    );

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtract is A + ~B + 1; the +1 rides in on the carry
                        a_q     <= a;
                        b_q     <= (op == OP_SUB) ? ~b : b;
                        carry_q <= (op == OP_SUB) ? 1'b1 : cin;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        // Results are only touched here so they stay stable
                        // between completions
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= acc_d;
                        cout_q  <= slice_cout;
                        ovf_q   <= signed_ovf(slice_c3, slice_cout);
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                DONE: begin
                    // Any start seen here is dropped; it must come back in IDLE
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : ripple_add_sequencer
`default_nettype wire

// File: tb/tb_ripple_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ripple_add_sequencer
//  Purpose  : Scoreboard bench for ripple_add_sequencer (WIDTH=16): directed
//             corner cases plus randomized operations against an arithmetic
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ripple_add_sequencer;

    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ripple_add_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    function automatic exp_t model(input logic o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic c);
        exp_t   e;
        longint ux, uy, ures, sx, sy, sres;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 1'b0) begin
            ures   = ux + uy + longint'(c);
            sres   = sx + sy + longint'(c);
            e.cout = (ures >= (64'sd1 <<< W));
        end else begin
            ures   = ux - uy;
            sres   = sx - sy;
            e.cout = (ux >= uy);
        end
        e.sum = W'(ures);
        e.ovf = (sres > ((64'sd1 <<< (W-1)) - 1)) || (sres < -(64'sd1 <<< (W-1)));
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum",  32'(sum),  32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("ovf",  32'(ovf),  32'(e.ovf));
            end
        end
    end

    // One operation. Called and returns on a falling edge with the DUT idle.
    // mode 0: quiet inputs; 1: random input churn incl. stray starts;
    // 2: start pulsed with other operands on the first two busy cycles and
    //    during the done cycle.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input int mode);
        op    = o;
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        exp_q.push_back(model(o, x, y, c));
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NSLICE; k++) begin
            chk("busy_run", 32'({busy, done}), 32'b10);
            if (mode == 1) begin
                a     = W'($urandom);
                b     = W'($urandom);
                op    = 1'($urandom);
                cin   = 1'($urandom);
                start = 1'($urandom);
            end else if (mode == 2 && k < 2) begin
                a     = 16'hAAAA;
                b     = 16'h5555;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_cycle", 32'({busy, done}), 32'b01);
        start = (mode == 2) ? 1'b1 : (mode == 1 ? 1'($urandom) : 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("after_done", 32'({busy, done}), 32'b00);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 0);
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(1'b0, 16'h1234, 16'h0000, 1'b1, 0);
        run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 0);
        run_op(1'b1, 16'h0007, 16'h0005, 1'b0, 0);
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_op(1'b1, 16'h0000, 16'h0000, 1'b0, 0);

        // Ignored starts during busy and done, then a quiet idle stretch
        run_op(1'b0, 16'h0010, 16'h0020, 1'b0, 2);
        for (int k = 0; k < 4; k++) begin
            chk("idle_no_done", 32'({busy, done}), 32'b00);
            @(negedge clk);
        end
        chk("held_sum", 32'(sum), 32'h0030);

        // Reset two edges after accept aborts without a done pulse
        op    = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum",  32'(sum),  32'd0);
        chk("abort_cout", 32'({cout, ovf}), 32'd0);
        for (int k = 0; k < NSLICE + 1; k++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        run_op(1'b0, 16'h0001, 16'h0002, 1'b0, 0);

        // Randomized operations with optional idle gaps
        for (int n = 0; n < 60; n++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ripple_add_sequencer
`default_nettype wire
